// File: rtl/dec_ram_pkg.sv
// Shared types and default widths for the hard-decision RAM ping-pong controller.
package dec_ram_pkg;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  localparam int DEF_DATA_WIDTH = 1;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_CODE_LEN   = 256;
  localparam int DEF_CNT_WIDTH  = 16;

endpackage

// File: rtl/dec_ram_pingpong_ctrl_fifo2.sv
// Two-entry valid/ready output buffer carrying a data word and its last tag.
// The head entry is never overwritten while it is presented, so data/last
// stay stable under backpressure.
module dec_out_fifo2
  import dec_ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_last,
  input  logic                  ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  last,
  output logic [1:0]            count
);

  logic [DATA_WIDTH:0] mem [0:1];
  logic                rd_ptr;
  logic                wr_ptr;
  logic                pop;

  assign valid = (count != 2'd0);
  assign pop   = valid && ready;
  assign {last, data} = mem[rd_ptr];

  // Storage, pointers and occupancy; the caller never pushes into a full buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {push_last, push_data};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dec_ram_pingpong_ctrl.sv
// Ping-pong controller for the two-bank hard-decision RAM: the decoder fills
// bank wb while the completed codeword in bank rb is streamed out.
//
// Per-bank state | meaning
// EMPTY          | no codeword held, writer may start here
// FILLING        | writer has stored part of a codeword
// FULL           | codeword complete, no read issued yet
// DRAINING       | reads in progress, freed on the out_last handshake
module dec_ram_pingpong_ctrl
  import dec_ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int CODE_LEN   = DEF_CODE_LEN,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [ADDR_WIDTH-1:0] ram_address  [0:1],
  output logic [DATA_WIDTH-1:0] ram_data_in  [0:1],
  output logic                  ram_we       [0:1],
  output logic                  ram_cs       [0:1],
  input  logic [DATA_WIDTH-1:0] ram_data_out [0:1],
  output logic [CNT_WIDTH-1:0]  frames_out,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CODE_LEN - 1);

  bank_state_t           state     [0:1];
  bank_state_t           state_nxt [0:1];
  logic                  wb;
  logic                  rb;
  logic                  run;
  logic [ADDR_WIDTH-1:0] rd_cnt;
  logic                  rd_done;
  logic                  rd_pend;
  logic                  rd_pend_last;
  logic [CNT_WIDTH-1:0]  frames_cnt;

  logic                  wr_fire;
  logic                  rd_issue;
  logic                  rd_last;
  logic                  out_fire;
  logic [1:0]            fifo_count;
  logic [1:0]            occupancy;
  logic                  fifo_valid;
  logic                  fifo_last;
  logic [DATA_WIDTH-1:0] fifo_data;

  // run holds everything quiet for one cycle after reset is released.
  assign wr_ready  = rst_n && run && (state[wb] == EMPTY || state[wb] == FILLING);
  assign wr_fire   = wr_valid && wr_ready;

  // The word leaving the buffer this cycle frees its slot, which keeps
  // the stream at one word per cycle when out_ready stays high.
  assign occupancy = fifo_count + {1'b0, rd_pend} - {1'b0, out_fire};
  assign rd_last   = (rd_cnt == LAST_ADDR);
  assign rd_issue  = rst_n && run && !rd_done && (occupancy < 2'd2) &&
                     (state[rb] == FULL || state[rb] == DRAINING);

  assign out_valid  = rst_n && fifo_valid;
  assign out_last   = out_valid && fifo_last;
  assign out_data   = rst_n ? fifo_data : '0;
  assign out_fire   = out_valid && out_ready;
  assign frames_out = frames_cnt;
  assign busy       = (state[0] != EMPTY) || (state[1] != EMPTY) || fifo_valid;

  // RAM port steering; bank states keep the write and read banks distinct.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      ram_cs[b]      = 1'b0;
      ram_we[b]      = 1'b0;
      ram_address[b] = '0;
      ram_data_in[b] = '0;
    end
    if (wr_fire) begin
      ram_cs[wb]      = 1'b1;
      ram_we[wb]      = 1'b1;
      ram_address[wb] = wr_addr;
      ram_data_in[wb] = wr_data;
    end
    if (rd_issue) begin
      ram_cs[rb]      = 1'b1;
      ram_address[rb] = rd_cnt;
    end
  end

  // Per-bank next state from write acceptance, first read and drain completion.
  always_comb begin
    state_nxt[0] = state[0];
    state_nxt[1] = state[1];
    if (wr_fire) begin
      state_nxt[wb] = wr_last ? FULL : FILLING;
    end
    if (rd_issue && state[rb] == FULL) begin
      state_nxt[rb] = DRAINING;
    end
    if (out_fire && fifo_last) begin
      state_nxt[rb] = EMPTY;
    end
  end

  // Bank states, pointers, read sequencing and the completed-frame count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state[0]     <= EMPTY;
      state[1]     <= EMPTY;
      wb           <= 1'b0;
      rb           <= 1'b0;
      run          <= 1'b0;
      rd_cnt       <= '0;
      rd_done      <= 1'b0;
      rd_pend      <= 1'b0;
      rd_pend_last <= 1'b0;
      frames_cnt   <= '0;
    end else begin
      run          <= 1'b1;
      state        <= state_nxt;
      rd_pend      <= rd_issue;
      rd_pend_last <= rd_issue && rd_last;
      if (wr_fire && wr_last) begin
        wb <= ~wb;
      end
      if (rd_issue) begin
        if (rd_last) begin
          rd_done <= 1'b1;
        end else begin
          rd_cnt <= rd_cnt + ADDR_WIDTH'(1);
        end
      end
      if (out_fire && fifo_last) begin
        rb         <= ~rb;
        rd_cnt     <= '0;
        rd_done    <= 1'b0;
        frames_cnt <= frames_cnt + CNT_WIDTH'(1);
      end
    end
  end

  // rb cannot move while a read is in flight, so it still selects the source bank.
  dec_out_fifo2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_pend),
    .push_data (ram_data_out[rb]),
    .push_last (rd_pend_last),
    .ready     (out_ready),
    .valid     (fifo_valid),
    .data      (fifo_data),
    .last      (fifo_last),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_dec_ram_pingpong_ctrl.sv
// Bench for dec_ram_pingpong_ctrl with CODE_LEN=4 and a behavioural RAM pair.
module tb_dec_ram_pingpong_ctrl;

  localparam int DW = 4;
  localparam int AW = 2;
  localparam int CL = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_last;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [AW-1:0] ram_address  [0:1];
  logic [DW-1:0] ram_data_in  [0:1];
  logic          ram_we       [0:1];
  logic          ram_cs       [0:1];
  logic [DW-1:0] ram_data_out [0:1];
  logic [CW-1:0] frames_out;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  dec_ram_pingpong_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CODE_LEN(CL), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_last(wr_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last),
    .ram_address(ram_address), .ram_data_in(ram_data_in), .ram_we(ram_we),
    .ram_cs(ram_cs), .ram_data_out(ram_data_out),
    .frames_out(frames_out), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural single-port synchronous-read RAMs.
  logic [DW-1:0] mem [0:1][0:CL-1];
  initial begin
    for (int b = 0; b < 2; b++) begin
      ram_data_out[b] = '0;
      for (int a = 0; a < CL; a++) mem[b][a] = '0;
    end
  end
  always @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (ram_cs[b]) begin
        if (ram_we[b]) mem[b][ram_address[b]] <= ram_data_in[b];
        else           ram_data_out[b] <= mem[b][ram_address[b]];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected output stream, filled as frames are written.
  typedef struct packed {
    logic [DW-1:0] d;
    logic          care;
    logic          last;
  } exp_t;
  exp_t q[$];

  // Protocol monitor: read bank/address order, no write into the draining
  // bank, at most two reads outstanding, stable output under stall, scoreboard.
  logic          rb_m;
  logic          rd_started;
  logic [AW-1:0] rd_addr_m;
  int            issued;
  int            popped;
  logic          stall_prev;
  logic [DW-1:0] prev_d;
  logic          prev_l;
  exp_t          e;
  logic          rd_seen;

  always @(negedge clk) begin
    if (!rst_n) begin
      rb_m = 1'b0; rd_started = 1'b0; rd_addr_m = '0;
      issued = 0; popped = 0; stall_prev = 1'b0;
      q.delete();
    end else begin
      rd_seen = 1'b0;
      for (int b = 0; b < 2; b++) begin
        if (ram_we[b]) begin
          chk("we_needs_cs", ram_cs[b], 1);
          chk("we_on_draining_bank", rd_started && (b == int'(rb_m)), 0);
        end
        if (ram_cs[b] && !ram_we[b]) begin
          chk("read_bank", b, rb_m);
          chk("read_addr", ram_address[b], rd_addr_m);
          rd_addr_m = rd_addr_m + 2'd1;
          rd_started = 1'b1;
          issued++;
          rd_seen = 1'b1;
        end
      end
      if (stall_prev) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_d);
        chk("stall_last", out_last, prev_l);
      end
      if (out_valid && out_ready) begin
        popped++;
        if (q.size() == 0) begin
          chk("unexpected_word", 1, 0);
        end else begin
          e = q.pop_front();
          if (e.care) chk("out_data", out_data, e.d);
          chk("out_last", out_last, e.last);
        end
        if (out_last) begin
          rb_m = ~rb_m; rd_started = 1'b0; rd_addr_m = '0;
        end
      end
      if (rd_seen) chk("outstanding_le2", (issued - popped) <= 2, 1);
      stall_prev = out_valid && !out_ready;
      prev_d = out_data;
      prev_l = out_last;
    end
  end

  task automatic push_frame(input logic [4*CL-1:0] w, input int n);
    exp_t x;
    for (int i = 0; i < CL; i++) begin
      x.d = w[4*i +: 4];
      x.care = (i < n);
      x.last = (i == CL - 1);
      q.push_back(x);
    end
  endtask

  // Writes words 0..n-1 of w, wr_last on the final one; exp_bank >= 0 checks the target bank.
  task automatic write_frame(input logic [4*CL-1:0] w, input int n, input int exp_bank);
    int t;
    push_frame(w, n);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_addr  = AW'(i);
      wr_data  = w[4*i +: 4];
      wr_last  = (i == n - 1);
      t = 0;
      @(negedge clk);
      while (!wr_ready && t < 300) begin
        @(negedge clk);
        t++;
      end
      if (!wr_ready) chk("wr_timeout", wr_ready, 1);
      if (i == 0 && exp_bank >= 0) chk("wr_bank", ram_we[exp_bank], 1);
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while ((busy || q.size() != 0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("idle_reached", busy || (q.size() != 0), 0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic          wv;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          wl;
    logic          ordy;
    logic          wrdy;
    logic          ov;
    logic [DW-1:0] od;
    logic          ol;
    logic          cs0;
    logic          we0;
    logic [AW-1:0] a0;
    logic          cs1;
    logic          bsy;
    logic [CW-1:0] fr;
  } vec_t;
  vec_t vt [0:10];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    int  t;
    logic done;

    //          wv  wa  wd  wl ordy wrdy ov  od  ol cs0 we0 a0 cs1 bsy fr
    vt[0]  = '{1, 0, 1, 0, 1,  1, 0, 0, 0, 1, 1, 0, 0, 0, 0};
    vt[1]  = '{1, 1, 0, 0, 1,  1, 0, 0, 0, 1, 1, 1, 0, 1, 0};
    vt[2]  = '{1, 2, 1, 0, 1,  1, 0, 0, 0, 1, 1, 2, 0, 1, 0};
    vt[3]  = '{1, 3, 1, 1, 1,  1, 0, 0, 0, 1, 1, 3, 0, 1, 0};
    vt[4]  = '{0, 0, 0, 0, 1,  1, 0, 0, 0, 1, 0, 0, 0, 1, 0};
    vt[5]  = '{0, 0, 0, 0, 1,  1, 0, 0, 0, 1, 0, 1, 0, 1, 0};
    vt[6]  = '{0, 0, 0, 0, 1,  1, 1, 1, 0, 1, 0, 2, 0, 1, 0};
    vt[7]  = '{0, 0, 0, 0, 1,  1, 1, 0, 0, 1, 0, 3, 0, 1, 0};
    vt[8]  = '{0, 0, 0, 0, 1,  1, 1, 1, 0, 0, 0, 0, 0, 1, 0};
    vt[9]  = '{0, 0, 0, 0, 1,  1, 1, 1, 1, 0, 0, 0, 0, 1, 0};
    vt[10] = '{0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0, 0, 0, 1};

    rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_last = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    wr_valid = 1'b1;
    @(negedge clk);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_ram_we0", ram_we[0], 0);
    chk("rst_ram_cs0", ram_cs[0], 0);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_wr_ready", wr_ready, 0);
    chk("release_out_valid", out_valid, 0);
    chk("release_frames", frames_out, 0);
    chk("release_busy", busy, 0);
    @(posedge clk); #1;

    // Single frame, cycle-exact against the vector table.
    push_frame(16'h1101, CL);
    for (int i = 0; i < 11; i++) begin
      wr_valid = vt[i].wv; wr_addr = vt[i].wa; wr_data = vt[i].wd;
      wr_last = vt[i].wl; out_ready = vt[i].ordy;
      @(negedge clk);
      chk($sformatf("v%0d_wr_ready", i), wr_ready, vt[i].wrdy);
      chk($sformatf("v%0d_out_valid", i), out_valid, vt[i].ov);
      if (vt[i].ov) chk($sformatf("v%0d_out_data", i), out_data, vt[i].od);
      chk($sformatf("v%0d_out_last", i), out_last, vt[i].ol);
      chk($sformatf("v%0d_cs0", i), ram_cs[0], vt[i].cs0);
      chk($sformatf("v%0d_we0", i), ram_we[0], vt[i].we0);
      if (vt[i].cs0) chk($sformatf("v%0d_addr0", i), ram_address[0], vt[i].a0);
      chk($sformatf("v%0d_cs1", i), ram_cs[1], vt[i].cs1);
      chk($sformatf("v%0d_busy", i), busy, vt[i].bsy);
      chk($sformatf("v%0d_frames", i), frames_out, vt[i].fr);
      @(posedge clk); #1;
    end
    wr_valid = 1'b0; wr_last = 1'b0;

    // Back-to-back frames A and B with the output stalled.
    out_ready = 1'b0;
    write_frame(16'h4321, CL, 1);
    write_frame(16'h8765, CL, 0);
    @(negedge clk);
    chk("both_full_wr_ready", wr_ready, 0);
    chk("both_full_out_valid", out_valid, 1);
    @(negedge clk);
    chk("both_full_wr_ready_hold", wr_ready, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    t = 0;
    @(negedge clk);
    while (frames_out != 2 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("frames_after_A", frames_out, 2);
    chk("wr_ready_after_A", wr_ready, 1);
    @(posedge clk); #1;
    // Frame C written into the freed bank while B drains.
    write_frame(16'hCBA9, CL, 1);
    wait_idle();
    chk("frames_after_ABC", frames_out, 4);

    // Backpressure pattern 1,0,0,1 while two frames pass through.
    done = 1'b0;
    fork
      begin
        write_frame(16'h5A3C, CL, -1);
        write_frame(16'hE1F0, CL, -1);
        wait_idle();
        done = 1'b1;
      end
      begin
        int k;
        k = 0;
        while (!done) begin
          out_ready = (k % 4 == 0) || (k % 4 == 3);
          k++;
          @(posedge clk); #1;
        end
      end
    join
    chk("frames_after_backpressure", frames_out, 6);

    // Reset in the middle of a drain, after two of four words.
    out_ready = 1'b0;
    write_frame(16'h2468, CL, -1);
    out_ready = 1'b1;
    n = 0; t = 0;
    while (n < 2 && t < 100) begin
      @(negedge clk);
      if (out_valid && out_ready) n++;
      t++;
    end
    chk("mid_drain_words", n, 2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    wr_valid = 1'b1; wr_addr = 2'd1; wr_data = 4'hF;
    @(negedge clk);
    chk("mid_rst_wr_ready", wr_ready, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_last", out_last, 0);
    for (int b = 0; b < 2; b++) begin
      chk($sformatf("mid_rst_cs%0d", b), ram_cs[b], 0);
      chk($sformatf("mid_rst_we%0d", b), ram_we[b], 0);
      chk($sformatf("mid_rst_addr%0d", b), ram_address[b], 0);
      chk($sformatf("mid_rst_din%0d", b), ram_data_in[b], 0);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_frames", frames_out, 0);
    chk("mid_rst_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wr_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_wr_ready_low", wr_ready, 0);
    chk("post_rst_no_output", out_valid, 0);
    @(posedge clk); #1;
    write_frame(16'h7E3D, CL, 0);
    wait_idle();
    chk("frames_after_reset_frame", frames_out, 1);

    // Degenerate frame: a single write carrying wr_last.
    write_frame(16'h0009, 1, 1);
    wait_idle();
    chk("frames_after_degenerate", frames_out, 2);
    chk("degenerate_wr_ready", wr_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
